// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared types and constants for the tank projectile controller
package tank_pkg;

   localparam int         COORD_W  = 10;
   localparam logic [7:0] FIRE_KEY = 8'h2C;

   typedef enum logic {READY, COOLDOWN} fire_state_t;

   typedef struct packed {
      logic               act;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } shot_t;

endpackage

// File: rtl/shot_slot.sv
// rtl/shot_slot.sv - one projectile slot: spawn, hit retire, top-edge retire, upward motion
module shot_slot
   import tank_pkg::*;
#(
   parameter int SHOT_STEP  = 4,
   parameter int SHOT_Y_MIN = 0
) (
   input  logic               frame_clk,
   input  logic               Reset,
   input  logic               load,
   input  logic [COORD_W-1:0] load_x,
   input  logic [COORD_W-1:0] load_y,
   input  logic               hit,
   output shot_t              shot
);

   // Below this Y a further step would cross the top edge, so the shot retires instead.
   localparam logic [COORD_W-1:0] Y_LIMIT = COORD_W'(SHOT_Y_MIN + SHOT_STEP);
   localparam logic [COORD_W-1:0] STEP    = COORD_W'(SHOT_STEP);

   shot_t shot_q;

   // Slot state update; a load only ever targets an idle slot, so it sits above the flight rules.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         shot_q <= '0;
      end else if (load) begin
         shot_q.act <= 1'b1;
         shot_q.x   <= load_x;
         shot_q.y   <= load_y;
      end else if (shot_q.act && hit) begin
         shot_q.act <= 1'b0;
      end else if (shot_q.act && (shot_q.y < Y_LIMIT)) begin
         shot_q.act <= 1'b0;
      end else if (shot_q.act) begin
         shot_q.y <= shot_q.y - STEP;
      end
   end

   assign shot = shot_q;

endmodule

// File: rtl/tank_shot_ctrl.sv
// rtl/tank_shot_ctrl.sv - fire-key edge detect, launch cooldown and projectile slot management
module tank_shot_ctrl #(
   parameter int NUM_SHOTS    = 4,
   parameter int SHOT_STEP    = 4,
   parameter int SPAWN_OFFSET = 8,
   parameter int SHOT_Y_MIN   = 0,
   parameter int COOLDOWN     = 10
) (
   input  logic                    frame_clk,
   input  logic                    Reset,
   input  logic [7:0]              keycode,
   input  logic [9:0]              TankX,
   input  logic [9:0]              TankY,
   input  logic [NUM_SHOTS-1:0]    ShotHit,
   output logic [NUM_SHOTS-1:0]    ShotActive,
   output logic [NUM_SHOTS*10-1:0] ShotX,
   output logic [NUM_SHOTS*10-1:0] ShotY,
   output logic                    FirePulse,
   output logic                    FireDrop
);

   import tank_pkg::*;

   // Counter only has to hold COOLDOWN-1.
   localparam int                 CNT_W     = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
   localparam logic [CNT_W-1:0]   CNT_INIT  = CNT_W'(COOLDOWN - 1);
   localparam logic [COORD_W-1:0] SPAWN_OFF = COORD_W'(SPAWN_OFFSET);
   localparam logic [COORD_W-1:0] SPAWN_MIN = COORD_W'(SHOT_Y_MIN + SPAWN_OFFSET);

   logic [7:0]           key_prev;
   logic                 press;
   fire_state_t          state;
   logic [CNT_W-1:0]     cnt;
   logic [NUM_SHOTS-1:0] act_vec;
   logic [NUM_SHOTS-1:0] free_onehot;
   logic                 free_found;
   logic                 attempt;
   logic                 launch;
   logic                 reject;
   logic [COORD_W-1:0]   spawn_y;
   shot_t                slot_q [NUM_SHOTS];

   // Remember last keycode so a held fire key counts as a single press.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) key_prev <= 8'h00;
      else       key_prev <= keycode;
   end

   assign press = (keycode == FIRE_KEY) && (key_prev != FIRE_KEY);

   // Lowest-index idle slot, judged on the flags registered before this edge.
   always_comb begin
      free_onehot = '0;
      free_found  = 1'b0;
      for (int i = 0; i < NUM_SHOTS; i++) begin
         if (!act_vec[i] && !free_found) begin
            free_onehot[i] = 1'b1;
            free_found     = 1'b1;
         end
      end
   end

   // A spawn above the legal top edge would underflow, so such a press is rejected.
   assign attempt = (state == tank_pkg::READY) && press;
   assign launch  = attempt && free_found && (TankY >= SPAWN_MIN);
   assign reject  = attempt && !launch;
   assign spawn_y = TankY - SPAWN_OFF;

   // Fire FSM: a launch blocks further launches for COOLDOWN frames; rejections stay READY.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state <= tank_pkg::READY;
         cnt   <= '0;
      end else begin
         case (state)
            tank_pkg::READY: begin
               if (launch) begin
                  state <= tank_pkg::COOLDOWN;
                  cnt   <= CNT_INIT;
               end
            end
            default: begin
               if (cnt == '0) state <= tank_pkg::READY;
               else           cnt   <= cnt - 1'b1;
            end
         endcase
      end
   end

   // One-frame launch and rejection indicators.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         FirePulse <= 1'b0;
         FireDrop  <= 1'b0;
      end else begin
         FirePulse <= launch;
         FireDrop  <= reject;
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_SHOTS; g++) begin : g_slot
         shot_slot #(
            .SHOT_STEP  (SHOT_STEP),
            .SHOT_Y_MIN (SHOT_Y_MIN)
         ) u_slot (
            .frame_clk (frame_clk),
            .Reset     (Reset),
            .load      (launch && free_onehot[g]),
            .load_x    (TankX),
            .load_y    (spawn_y),
            .hit       (ShotHit[g]),
            .shot      (slot_q[g])
         );
      end
   endgenerate

   // Flatten slot records onto the sprite/collision buses.
   always_comb begin
      act_vec = '0;
      ShotX   = '0;
      ShotY   = '0;
      for (int i = 0; i < NUM_SHOTS; i++) begin
         act_vec[i]          = slot_q[i].act;
         ShotX[10*i +: 10]   = slot_q[i].x;
         ShotY[10*i +: 10]   = slot_q[i].y;
      end
   end

   assign ShotActive = act_vec;

endmodule

// File: tb/tb_tank_shot_ctrl.sv
// tb/tb_tank_shot_ctrl.sv - scoreboard bench for tank_shot_ctrl
module tb_tank_shot_ctrl;

   logic        frame_clk;
   logic        Reset;
   logic [7:0]  keycode;
   logic [9:0]  TankX;
   logic [9:0]  TankY;
   logic [3:0]  ShotHit;
   logic [3:0]  ShotActive;
   logic [39:0] ShotX;
   logic [39:0] ShotY;
   logic        FirePulse;
   logic        FireDrop;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      string      tag;
      logic [3:0] act;
      logic       pulse;
      logic       drop;
      int         slot;
      logic [9:0] x;
      logic [9:0] y;
   } exp_t;

   exp_t sb[$];

   tank_shot_ctrl dut (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .keycode    (keycode),
      .TankX      (TankX),
      .TankY      (TankY),
      .ShotHit    (ShotHit),
      .ShotActive (ShotActive),
      .ShotX      (ShotX),
      .ShotY      (ShotY),
      .FirePulse  (FirePulse),
      .FireDrop   (FireDrop)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   task automatic push(input string tag, input logic [3:0] act, input logic pulse,
                       input logic drop, input int slot, input logic [9:0] x, input logic [9:0] y);
      exp_t e;
      e.tag = tag; e.act = act; e.pulse = pulse; e.drop = drop;
      e.slot = slot; e.x = x; e.y = y;
      sb.push_back(e);
   endtask

   task automatic check_now();
      exp_t e;
      logic [9:0] ox, oy;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_assert++;
         assert (ShotActive === e.act) else begin
            n_fail++;
            $error("FAIL %s ShotActive observed=%b expected=%b", e.tag, ShotActive, e.act);
         end
         n_assert++;
         assert (FirePulse === e.pulse) else begin
            n_fail++;
            $error("FAIL %s FirePulse observed=%b expected=%b", e.tag, FirePulse, e.pulse);
         end
         n_assert++;
         assert (FireDrop === e.drop) else begin
            n_fail++;
            $error("FAIL %s FireDrop observed=%b expected=%b", e.tag, FireDrop, e.drop);
         end
         if (e.slot >= 0) begin
            ox = ShotX[e.slot*10 +: 10];
            oy = ShotY[e.slot*10 +: 10];
            n_assert++;
            assert (ox === e.x) else begin
               n_fail++;
               $error("FAIL %s X[%0d] observed=%0d expected=%0d", e.tag, e.slot, ox, e.x);
            end
            n_assert++;
            assert (oy === e.y) else begin
               n_fail++;
               $error("FAIL %s Y[%0d] observed=%0d expected=%0d", e.tag, e.slot, oy, e.y);
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge frame_clk);
      #1;
      check_now();
   endtask

   task automatic do_reset();
      keycode = 8'h00;
      ShotHit = 4'b0000;
      Reset   = 1'b1;
      #2;
      Reset   = 1'b0;
   endtask

   initial begin
      Reset   = 1'b1;
      keycode = 8'h00;
      TankX   = 10'd0;
      TankY   = 10'd0;
      ShotHit = 4'b0000;
      #2;
      push("reset_s0", 4'b0000, 1'b0, 1'b0, 0, 10'd0, 10'd0);
      push("reset_s3", 4'b0000, 1'b0, 1'b0, 3, 10'd0, 10'd0);
      check_now();
      Reset = 1'b0;

      // Single launch, then hold the key for 20 frames.
      TankX = 10'd350; TankY = 10'd500; keycode = 8'h2C;
      push("t1_launch", 4'b0001, 1'b1, 1'b0, 0, 10'd350, 10'd492);
      tick();
      push("t1_move", 4'b0001, 1'b0, 1'b0, 0, 10'd350, 10'd488);
      tick();
      for (int i = 0; i < 18; i++) begin
         push($sformatf("t2_hold%0d", i), 4'b0001, 1'b0, 1'b0, 0, 10'd350,
              10'(488 - 4*(i+1)));
         tick();
      end

      // Presses every 11 frames fill all slots; a press 3 frames after a launch is ignored.
      do_reset();
      TankY = 10'd400;
      for (int e = 0; e <= 45; e++) begin
         int       n;
         logic [3:0] a;
         keycode = ((e % 11 == 0) || (e == 3)) ? 8'h2C : 8'h00;
         TankX   = 10'(100 + e);
         n = (e / 11) + 1;
         if (n > 4) n = 4;
         a = 4'((1 << n) - 1);
         if ((e % 11 == 0) && (e < 44))
            push($sformatf("t3_launch%0d", e), a, 1'b1, 1'b0, e / 11, 10'(100 + e), 10'd392);
         else if (e == 44)
            push("t3_full_drop", a, 1'b0, 1'b1, 0, 10'd100, 10'd216);
         else if (e == 45)
            push("t3_after_drop", a, 1'b0, 1'b0, 1, 10'd111, 10'(392 - 4*34));
         else
            push($sformatf("t3_e%0d", e), a, 1'b0, 1'b0, -1, 10'd0, 10'd0);
         tick();
      end

      // Top-edge retire: Y 9 -> 5 -> 1 -> retired holding 1.
      do_reset();
      TankX = 10'd50; TankY = 10'd17; keycode = 8'h2C;
      push("t4_spawn", 4'b0001, 1'b1, 1'b0, 0, 10'd50, 10'd9);
      tick();
      keycode = 8'h00;
      push("t4_y5", 4'b0001, 1'b0, 1'b0, 0, 10'd50, 10'd5);
      tick();
      push("t4_y1", 4'b0001, 1'b0, 1'b0, 0, 10'd50, 10'd1);
      tick();
      push("t4_retire", 4'b0000, 1'b0, 1'b0, 0, 10'd50, 10'd1);
      tick();
      push("t4_hold", 4'b0000, 1'b0, 1'b0, 0, 10'd50, 10'd1);
      tick();

      // Hit on slot0 coincides with a launch: the freed slot is not reused on that edge.
      do_reset();
      TankX = 10'd200; TankY = 10'd300;
      for (int e = 0; e <= 22; e++) begin
         logic [3:0] a;
         keycode = ((e == 0) || (e == 11) || (e == 22)) ? 8'h2C : 8'h00;
         ShotHit = (e == 22) ? 4'b0001 : 4'b0000;
         a = (e < 11) ? 4'b0001 : ((e < 22) ? 4'b0011 : 4'b0110);
         if (e == 22) begin
            push("t5_slot2", a, 1'b1, 1'b0, 2, 10'd200, 10'd292);
            push("t5_slot0_hold", a, 1'b1, 1'b0, 0, 10'd200, 10'd208);
         end else begin
            push($sformatf("t5_e%0d", e), a, (e == 0) || (e == 11), 1'b0, -1, 10'd0, 10'd0);
         end
         tick();
      end
      keycode = 8'h00;
      ShotHit = 4'b1000;
      push("t5_idle_hit", 4'b0110, 1'b0, 1'b0, 2, 10'd200, 10'd288);
      push("t5_slot0_still", 4'b0110, 1'b0, 1'b0, 0, 10'd200, 10'd208);
      tick();
      ShotHit = 4'b0000;

      // Spawn above the top edge is rejected; async reset mid-flight clears everything.
      do_reset();
      TankX = 10'd30; TankY = 10'd7; keycode = 8'h2C;
      push("t6_drop", 4'b0000, 1'b0, 1'b1, -1, 10'd0, 10'd0);
      tick();
      keycode = 8'h00;
      push("t6_drop_clear", 4'b0000, 1'b0, 1'b0, -1, 10'd0, 10'd0);
      tick();
      TankY = 10'd100; keycode = 8'h2C;
      push("t6_launch", 4'b0001, 1'b1, 1'b0, 0, 10'd30, 10'd92);
      tick();
      keycode = 8'h00;
      push("t6_move", 4'b0001, 1'b0, 1'b0, 0, 10'd30, 10'd88);
      tick();
      Reset = 1'b1;
      #1;
      push("t6_async_clear", 4'b0000, 1'b0, 1'b0, 0, 10'd0, 10'd0);
      check_now();
      Reset = 1'b0;
      TankX = 10'd40; keycode = 8'h2C;
      push("t6_relaunch", 4'b0001, 1'b1, 1'b0, 0, 10'd40, 10'd92);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
